// File: rtl/overdrive_pipe.sv
// Three-stage valid/ready overdrive: pre-gain with saturation, square, then
// bypass / hard clip / cubic soft clip selected per sample.
module overdrive_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 12,
    parameter int GAIN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic        [GAIN_W-1:0] in_gain,
    input  logic        [1:0]        in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_HARD   = 2'd1,
        MODE_SOFT   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam int PW = 2*DATA_W + GAIN_W;
    localparam int SW = 2*DATA_W;
    localparam int CW = 3*DATA_W;

    localparam logic signed [DATA_W-1:0] ONE   = (DATA_W)'(2**FRAC_W);
    localparam logic signed [DATA_W-1:0] HALF  = (DATA_W)'(2**(FRAC_W-1));
    localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0]     RND_P = (PW)'(2**FRAC_W - 1);
    localparam logic signed [CW-1:0]     RND_C = (CW)'(2**FRAC_W - 1);

    logic                     v1, v2;
    logic signed [DATA_W-1:0] g1, g2;
    logic signed [SW-1:0]     s2;
    mode_e                    m1, m2;

    assign in_ready = !out_valid || out_ready;

    // Stage 1: sample * gain, divide by One toward zero, saturate to DATA_W
    logic signed [PW-1:0]     a1, b1, p1, q1;
    logic                     ovf1;
    logic signed [DATA_W-1:0] g_sat;

    assign a1    = {{(PW-DATA_W){in_sample[DATA_W-1]}}, in_sample};
    assign b1    = {{(PW-GAIN_W){1'b0}}, in_gain};
    assign p1    = a1 * b1;
    assign q1    = p1[PW-1] ? ((p1 + RND_P) >>> FRAC_W) : (p1 >>> FRAC_W);
    assign ovf1  = !((&q1[PW-1:DATA_W-1]) || !(|q1[PW-1:DATA_W-1]));
    assign g_sat = ovf1 ? (q1[PW-1] ? MIN_D : MAX_D) : q1[DATA_W-1:0];

    // Stage 2: g*g is never negative, so a plain shift truncates toward zero
    logic signed [SW-1:0] a2, p2, s_next;

    assign a2     = {{DATA_W{g1[DATA_W-1]}}, g1};
    assign p2     = a2 * a2;
    assign s_next = p2 >>> FRAC_W;

    // Stage 3: cubic term (mul(s,g) + 3g) / 4, both divisions toward zero
    logic signed [CW-1:0]     a3, b3, p3, c3, sum3, t3;
    logic                     ovf3;
    logic signed [DATA_W-1:0] soft_lin;
    logic signed [DATA_W-1:0] y;

    assign a3       = {{(CW-SW){s2[SW-1]}}, s2};
    assign b3       = {{(CW-DATA_W){g2[DATA_W-1]}}, g2};
    assign p3       = a3 * b3;
    assign c3       = p3[CW-1] ? ((p3 + RND_C) >>> FRAC_W) : (p3 >>> FRAC_W);
    assign sum3     = c3 + b3 + (b3 <<< 1);
    assign t3       = sum3[CW-1] ? ((sum3 + (CW)'(3)) >>> 2) : (sum3 >>> 2);
    assign ovf3     = !((&t3[CW-1:DATA_W-1]) || !(|t3[CW-1:DATA_W-1]));
    assign soft_lin = ovf3 ? (t3[CW-1] ? MIN_D : MAX_D) : t3[DATA_W-1:0];

    always_comb begin
        y = g2;
        case (m2)
            MODE_HARD: begin
                if (g2 > HALF)
                    y = HALF;
                else if (g2 < -HALF)
                    y = -HALF;
            end
            MODE_SOFT: begin
                if (g2 <= -ONE)
                    y = -HALF;
                else if (g2 >= ONE)
                    y = HALF;
                else
                    y = soft_lin;
            end
            default: y = g2;
        endcase
    end

    // Whole pipe advances as one unit whenever the output slot can move
    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            g1         <= '0;
            m1         <= MODE_BYPASS;
            v2         <= 1'b0;
            g2         <= '0;
            s2         <= '0;
            m2         <= MODE_BYPASS;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else if (in_ready) begin
            v1         <= in_valid;
            g1         <= g_sat;
            m1         <= mode_e'(in_mode);
            v2         <= v1;
            g2         <= g1;
            s2         <= s_next;
            m2         <= m1;
            out_valid  <= v2;
            out_sample <= y;
        end
    end

endmodule

// File: tb/tb_overdrive_pipe.sv
// Randomized and directed bench for overdrive_pipe, scored against a
// plain-arithmetic reference of the transfer function.
module tb_overdrive_pipe;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 12;
    localparam int GAIN_W = 16;
    localparam longint ONE  = 4096;
    localparam longint GMAX = 64'sd2147483647;
    localparam longint GMIN = -64'sd2147483648;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_sample;
    logic        [GAIN_W-1:0] in_gain;
    logic        [1:0]        in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_sample;

    overdrive_pipe #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .GAIN_W(GAIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_gain   (in_gain),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     vectors;
    int     miscompares;
    int     cyc;
    int     n_out;
    bit     lat_mode;
    bit     hold_prev;
    longint prev_sample;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: integer division in SV already truncates toward zero
    function automatic longint ref_out(input longint smp, input longint gn, input int md);
        longint g, s, c;
        g = (smp * gn) / ONE;
        if (g > GMAX) g = GMAX;
        if (g < GMIN) g = GMIN;
        case (md)
            1: begin
                if (g > ONE/2)  return ONE/2;
                if (g < -ONE/2) return -ONE/2;
                return g;
            end
            2: begin
                if (g <= -ONE) return -ONE/2;
                if (g >= ONE)  return ONE/2;
                s = (g * g) / ONE;
                c = (s * g) / ONE;
                return (c + 3*g) / 4;
            end
            default: return g;
        endcase
    endfunction

    task automatic cycle(input bit v, input longint smp, input longint gn,
                         input int md, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_sample = smp[DATA_W-1:0];
        in_gain   = gn[GAIN_W-1:0];
        in_mode   = md[1:0];
        out_ready = ordy;
        #1;
        cyc++;
        check("in_ready", in_ready, (!out_valid || out_ready));
        if (hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_sample, prev_sample);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("data", out_sample, e.val);
                if (lat_mode) check("latency", cyc - e.cyc, 3);
            end
        end
        if (in_valid && in_ready) begin
            e.val = ref_out(smp, gn, md);
            e.cyc = cyc;
            sb.push_back(e);
        end
        hold_prev   = out_valid && !out_ready;
        prev_sample = out_sample;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(0, 0, 0, 0, 1);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic directed(input string tag, input longint smp, input longint gn,
                            input int md, input longint expv);
        cycle(1, smp, gn, md, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check({tag, "_early"}, out_valid, 0);
        cycle(0, 0, 0, 0, 1);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_value"}, out_sample, expv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sample = 32'sd1000;
        in_gain   = 16'd4096;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_in_ready", in_ready, 1);
        sb.delete();
        hold_prev = 1'b0;
    endtask

    function automatic longint rand_sample(input int cls);
        int r;
        case (cls)
            0:       r = int'($urandom_range(0, 24000)) - 12000;
            1:       r = $urandom();
            2:       r = int'($urandom_range(0, 140000)) - 70000;
            default: r = (int'($urandom_range(0, 8)) - 4) * 4096 + int'($urandom_range(0, 2)) - 1;
        endcase
        return longint'(r);
    endfunction

    initial begin
        int     n0, cls;
        longint gn;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        n_out       = 0;
        lat_mode    = 1'b1;
        hold_prev   = 1'b0;
        prev_sample = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sample   = '0;
        in_gain     = '0;
        in_mode     = '0;
        out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sample", out_sample, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);

        directed("soft_2048",  2048,       4096, 2, 1664);
        directed("soft_m2048", -2048,      4096, 2, -1664);
        directed("soft_5000",  5000,       4096, 2, 2048);
        directed("soft_m4096", -4096,      4096, 2, -2048);
        directed("hard_3000",  3000,       4096, 1, 2048);
        directed("byp_1000",   1000,       8192, 0, 2000);
        directed("byp_sat",    1073741824, 8192, 0, 2147483647);
        directed("rsvd_1000",  1000,       8192, 3, 2000);
        drain();

        n0 = n_out;
        for (int i = 0; i < 8; i++)
            cycle(1, rand_sample(0), longint'($urandom_range(3000, 5500)), i % 3, 1);
        repeat (4) cycle(0, 0, 0, 0, 1);
        check("burst_count", n_out - n0, 8);
        drain();

        lat_mode = 1'b0;
        for (int i = 0; i < 4; i++)
            cycle(1, rand_sample(0), 4096, 2, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, rand_sample(0), 4096, 1, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        for (int i = 0; i < 4; i++)
            cycle(1, rand_sample(2), 4096, 0, 1);
        drain();

        for (int i = 0; i < 3; i++)
            cycle(1, rand_sample(0), 4096, 2, 1);
        do_reset();
        repeat (6) cycle(0, 0, 0, 0, 1);
        check("post_rst_empty", sb.size(), 0);

        for (int i = 0; i < 3000; i++) begin
            cls = int'($urandom_range(0, 3));
            gn  = (cls == 0 || cls == 3) ? longint'($urandom_range(3000, 5500))
                                         : longint'($urandom_range(0, 65535));
            cycle($urandom_range(0, 3) != 0, rand_sample(cls), gn,
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        end
        drain();

        lat_mode = 1'b1;
        for (int s = -65536; s <= 65535; s += 2)
            cycle(1, longint'(s), 4096, 2, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
